// File: rtl/tx_channel_arbiter.sv
// tx_channel_arbiter: round-robin sharing of one tx_unit among sampler channels, optional channel-ID header per sample
module tx_channel_arbiter #(
  parameter int         N_CHANNELS  = 2,
  parameter int         DATA_SIZE   = 8,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BASE = 8'hF0,
  parameter int         BUSY_WAIT   = 4
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [N_CHANNELS-1:0]           i_enable,
  input  logic [N_CHANNELS-1:0]           i_valid,
  input  logic [N_CHANNELS*DATA_SIZE-1:0] i_data,
  output logic [N_CHANNELS-1:0]           o_next,
  input  logic                            i_txready,
  output logic                            o_send,
  output logic [DATA_SIZE-1:0]            o_txdata,
  output logic [$clog2(N_CHANNELS)-1:0]   o_grant,
  output logic                            o_busy,
  output logic                            o_error
);
  localparam int GW = $clog2(N_CHANNELS);
  localparam int CW = $clog2(BUSY_WAIT + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                  state_q;
  logic [GW-1:0]           ptr_q;
  logic                    data_phase_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_SIZE-1:0]    data_q;
  logic [N_CHANNELS-1:0]   req;
  logic [GW-1:0]           win;
  logic                    found;
  logic [DATA_SIZE-1:0]    win_data;
  logic [7:0]              hdr;
  assign req      = i_valid & i_enable;
  assign win_data = i_data[int'(win)*DATA_SIZE +: DATA_SIZE];
  assign hdr      = HEADER_BASE + 8'(win);
  // pick the first requester after the pointer; scanning farthest-first lets the nearest overwrite
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = N_CHANNELS; i >= 1; i--) begin
      if (req[(int'(ptr_q) + i) % N_CHANNELS]) begin
        win   = GW'((int'(ptr_q) + i) % N_CHANNELS);
        found = 1'b1;
      end
    end
  end
  // transaction FSM: grant, send header/data, watch tx_unit handshake; all outputs registered here
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      ptr_q        <= GW'(N_CHANNELS - 1);
      data_phase_q <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
      o_send       <= 1'b0;
      o_next       <= '0;
      o_txdata     <= '0;
      o_grant      <= '0;
      o_busy       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_send <= 1'b0;
      o_next <= '0;
      case (state_q)
        IDLE: if (found && i_txready) begin
          data_q       <= win_data;
          ptr_q        <= win;
          o_grant      <= win;
          o_next       <= {{(N_CHANNELS-1){1'b0}}, 1'b1} << win;
          o_txdata     <= HEADER_EN ? DATA_SIZE'(hdr) : win_data;
          data_phase_q <= !HEADER_EN;
          o_send       <= 1'b1;
          o_busy       <= 1'b1;
          state_q      <= SEND;
        end
        SEND: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!i_txready) begin
          state_q <= WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          o_error      <= 1'b1;
          o_busy       <= 1'b0;
          data_phase_q <= 1'b0;
          state_q      <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        WAIT_DONE: if (i_txready) begin
          if (!data_phase_q) begin
            data_phase_q <= 1'b1;
            o_txdata     <= data_q;
            o_send       <= 1'b1;
            state_q      <= SEND;
          end else begin
            o_busy  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_channel_arbiter.sv
// tb_tx_channel_arbiter: directed checks of grant rotation, framing, masking, busy timeout and async reset
module tb_tx_channel_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] en = 2'b11;
  logic [1:0] va = 2'b00;
  logic [15:0] da = '0;
  logic [1:0] a_next;
  logic       a_ready, a_send, a_busy, a_error;
  logic [7:0] a_txdata;
  logic       a_grant;
  logic [1:0] eb = 2'b11;
  logic [1:0] vb = 2'b00;
  logic [15:0] db = '0;
  logic [1:0] b_next;
  logic       b_ready, b_send, b_busy, b_error;
  logic [7:0] b_txdata;
  logic       b_grant;
  logic       dead = 1'b0;
  int         blen = 3;
  int         a_left, b_left;
  int         n_cmp = 0, n_err = 0;
  int         nxt0 = 0, nxt1 = 0, b_sends = 0;
  logic [7:0] bytes[$];
  logic       grants[$];
  tx_channel_arbiter #(.N_CHANNELS(2), .DATA_SIZE(8), .HEADER_EN(1'b1), .HEADER_BASE(8'hF0), .BUSY_WAIT(4)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(va), .i_data(da), .o_next(a_next),
    .i_txready(a_ready), .o_send(a_send), .o_txdata(a_txdata), .o_grant(a_grant), .o_busy(a_busy), .o_error(a_error));
  tx_channel_arbiter #(.N_CHANNELS(2), .DATA_SIZE(8), .HEADER_EN(1'b0), .HEADER_BASE(8'hF0), .BUSY_WAIT(4)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_enable(eb), .i_valid(vb), .i_data(db), .o_next(b_next),
    .i_txready(b_ready), .o_send(b_send), .o_txdata(b_txdata), .o_grant(b_grant), .o_busy(b_busy), .o_error(b_error));
  always #5 clk = ~clk;
  // tx_unit models: go busy for a fixed time after each start pulse; 'dead' makes unit a ignore starts
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin a_ready <= 1'b1; a_left <= 0; end
    else if (a_send && !dead) begin a_ready <= 1'b0; a_left <= blen; end
    else if (a_left > 1) a_left <= a_left - 1;
    else if (a_left == 1) begin a_left <= 0; a_ready <= 1'b1; end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin b_ready <= 1'b1; b_left <= 0; end
    else if (b_send) begin b_ready <= 1'b0; b_left <= 3; end
    else if (b_left > 1) b_left <= b_left - 1;
    else if (b_left == 1) begin b_left <= 0; b_ready <= 1'b1; end
  always @(negedge clk) begin
    if (a_send) begin bytes.push_back(a_txdata); grants.push_back(a_grant); end
    if (a_next[0]) nxt0++;
    if (a_next[1]) nxt1++;
    if (b_send) b_sends++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_a_idle();
    int k = 0;
    while (a_busy && k < 500) begin @(negedge clk); k++; end
    chk("a_idle_timeout", {31'd0, a_busy}, 0);
  endtask
  task automatic wait_bytes(input int n);
    int k = 0;
    while (bytes.size() < n && k < 2000) begin @(negedge clk); k++; end
    chk("bytes_timeout", {31'd0, bytes.size() >= n}, 1);
  endtask
  task automatic clear_log();
    bytes.delete(); grants.delete(); nxt0 = 0; nxt1 = 0;
  endtask
  initial begin
    logic [7:0] exp2 [8];
    exp2 = '{8'hF0, 8'h11, 8'hF1, 8'h22, 8'hF0, 8'h11, 8'hF1, 8'h22};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {28'd0, a_send, a_busy, a_error, |a_next}, 0);
    chk("rst_txdata", a_txdata, 0);
    chk("rst_grant", a_grant, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single channel, slow tx_unit, data changed after the o_next pulse
    blen = 20; clear_log();
    va = 2'b10; da = 16'h5A00;
    @(negedge clk);
    chk("t1_next", a_next, 2'b10);
    chk("t1_send", a_send, 1);
    chk("t1_hdr", a_txdata, 8'hF1);
    chk("t1_grant", a_grant, 1);
    va = 2'b00; da = 16'hEE00;
    wait_a_idle();
    chk("t1_nbytes", bytes.size(), 2);
    chk("t1_b0", bytes[0], 8'hF1);
    chk("t1_b1", bytes[1], 8'h5A);
    chk("t1_nxt1", nxt1, 1);
    // both channels requesting continuously: strict rotation
    blen = 3; clear_log();
    va = 2'b11; da = 16'h2211;
    wait_bytes(8);
    va = 2'b00;
    wait_a_idle();
    for (int i = 0; i < 8; i++) chk($sformatf("t2_byte%0d", i), bytes[i], exp2[i]);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), grants[2*i], i % 2);
    // ch0 masked: only ch1 served
    clear_log();
    en = 2'b10; va = 2'b11;
    wait_bytes(6);
    va = 2'b00;
    wait_a_idle();
    for (int i = 0; i < 6; i++) chk($sformatf("t3_byte%0d", i), bytes[i], i % 2 ? 8'h22 : 8'hF1);
    chk("t3_nxt0", nxt0, 0);
    en = 2'b11;
    // header disabled instance: data only, one start per sample
    vb = 2'b01; db = 16'h003C;
    @(negedge clk);
    chk("t4_send", b_send, 1);
    chk("t4_data", b_txdata, 8'h3C);
    chk("t4_next", b_next, 2'b01);
    vb = 2'b00; db = '0;
    begin
      int k = 0;
      while (b_busy && k < 200) begin @(negedge clk); k++; end
    end
    chk("t4_idle", b_busy, 0);
    chk("t4_nsend", b_sends, 1);
    // tx_unit never goes busy: error after BUSY_WAIT cycles, then recovery
    clear_log(); dead = 1'b1;
    va = 2'b01; da = 16'h0044;
    @(negedge clk);
    chk("t5_send", a_send, 1);
    chk("t5_grant", a_grant, 0);
    va = 2'b00;
    repeat (4) @(negedge clk);
    chk("t5_err_early", {30'd0, a_error, a_busy}, 2'b01);
    @(negedge clk);
    chk("t5_err", {30'd0, a_error, a_busy}, 2'b10);
    chk("t5_nxt0", nxt0, 1);
    dead = 1'b0; clear_log();
    va = 2'b10; da = 16'h7700;
    @(negedge clk);
    chk("t5_regrant", a_grant, 1);
    va = 2'b00;
    wait_a_idle();
    chk("t5_b0", bytes[0], 8'hF1);
    chk("t5_b1", bytes[1], 8'h77);
    chk("t5_sticky", a_error, 1);
    // async reset while the header is in flight
    blen = 20;
    va = 2'b10; da = 16'h9900;
    @(negedge clk);
    va = 2'b00;
    repeat (5) @(negedge clk);
    chk("t6_busy_before", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {28'd0, a_send, a_busy, a_error, |a_next}, 0);
    chk("t6_rst_txdata", a_txdata, 0);
    va = 2'b11; da = 16'h2211;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_grant", a_grant, 0);
    chk("t6_next", a_next, 2'b01);
    chk("t6_hdr", a_txdata, 8'hF0);
    va = 2'b00;
    wait_a_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
